vga_video_out_pipe: RTL and testbench
=====================================

VGA_VIDEO_OUT_PIPE -- requirements
Module: vga_video_out_pipe

Interface
REQ-001 Parameter COLOR_BITS, default 4: bits per colour channel, legal range 1..8.
REQ-002 Parameter PIPE_DEPTH, default 2: input-to-output latency in cycles, legal range 1..4.
REQ-003 Parameter HSYNC_ACTIVE_LOW, default 1: output hsync polarity; 1 = active-low.
REQ-004 Parameter VSYNC_ACTIVE_LOW, default 1: output vsync polarity; 1 = active-low.
REQ-005 Parameter BAR_WIDTH, default 80: active pixels per colour bar, legal range 1..511.
REQ-006 pixel_clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 vga_red_data / vga_green_data / vga_blue_data  in  COLOR_BITS each  source pixel colour.
REQ-009 h_synch / v_synch  in  1  active-high sync pulses from the timing generator.
REQ-010 blank  in  1  high outside the active video area.
REQ-011 mode  in  2  requested mode: 0 pass-through, 1 solid fill, 2 colour bars, 3 forced black.
REQ-012 fill_rgb  in  3*COLOR_BITS  solid-fill colour as {R,G,B}.
REQ-013 VGA_HSYNCH / VGA_VSYNCH  out  1  polarity-adjusted, registered syncs.
REQ-014 VGA_OUT_RED / VGA_OUT_GREEN / VGA_OUT_BLUE  out  COLOR_BITS each  registered colour.
REQ-015 active_mode  out  2  mode currently in effect.

Function
REQ-016 Output syncs SHALL equal the inputs, inverted when the matching *_ACTIVE_LOW parameter is 1.
REQ-017 Every output (syncs, colours, blank effect) SHALL lag its inputs by exactly PIPE_DEPTH cycles, all aligned.
REQ-018 Colour SHALL be computed in pipeline stage 1; stages 2..PIPE_DEPTH are pure delay registers.
REQ-019 blank=1 SHALL force colour 0 regardless of mode.
REQ-020 Mode 0 SHALL output the source pixel colour unchanged.
REQ-021 Mode 1 SHALL output the latched fill colour.
REQ-022 Mode 2 SHALL output 8 vertical bars, each full-scale (all ones) or 0 per channel: white, yellow, cyan, green, magenta, red, blue, black.
REQ-023 Mode 3 SHALL output colour 0.
REQ-024 A 12-bit pixel counter SHALL increment on each cycle with blank=0, clear on any cycle with blank=1, and saturate at 4095.
REQ-025 Bar index SHALL be pixel counter / BAR_WIDTH, clamped to 7; pixels beyond bar 7 stay black.
REQ-026 The mode and fill_rgb inputs SHALL be latched only on the cycle after a v_synch rising edge (v_synch high, previous v_synch low).
REQ-027 The latched mode SHALL drive active_mode and take effect from the cycle after the latch.
REQ-028 Mode/fill changes at any other time SHALL be ignored; a mid-frame change never tears a frame.
REQ-029 A v_synch rising edge coinciding with blank=0 SHALL still latch; blank forcing is unaffected.

Reset
REQ-030 While reset=0, colour outputs SHALL be 0 and syncs SHALL hold the inactive level (1 if *_ACTIVE_LOW=1, else 0).
REQ-031 While reset=0, active_mode SHALL be 0, latched fill 0, pixel counter 0, v_synch edge register 0, and all pipeline stages cleared to blanked/inactive.
REQ-032 Reset SHALL act immediately when asserted, including mid-line and mid-frame.
REQ-033 After release, the first valid output SHALL appear PIPE_DEPTH cycles after the first sampled input.

Verification
REQ-034 Defaults, mode 0, blank=0, red=4'hA, green=4'h5, blue=4'h3, h_synch=1 -> 2 cycles later RGB=A/5/3 and VGA_HSYNCH=0.
REQ-035 Mode 0 with blank=1 and red=4'hF -> all colour outputs 0 after 2 cycles; syncs still follow the inputs.
REQ-036 mode=1, fill=12'h0F0, changed mid-frame -> output stays pass-through until the next v_synch rising edge, then shows G=F, R=B=0 with active_mode=1.
REQ-037 Mode 2, BAR_WIDTH=80, 640-pixel active line -> pixel 0 white, 79 white, 80 yellow, 560 black; counter clears on blank.
REQ-038 reset driven low mid-line -> next sample shows colours 0, HSYNC=VSYNC=1, active_mode=0; after release, pass-through resumes after 2 cycles.
REQ-039 PIPE_DEPTH=4, HSYNC_ACTIVE_LOW=0, single-cycle h_synch pulse -> one-cycle high VGA_HSYNCH exactly 4 cycles later, aligned with the colour.

Source files
------------

// File: rtl/vga_video_out_pipe_if.sv
// Pixel-side bundle between the timing/source logic (master) and the
// video output pipe (slave).
interface vga_video_out_pipe_if #(
  parameter int COLOR_BITS = 4
);
  logic [COLOR_BITS-1:0]   vga_red_data;
  logic [COLOR_BITS-1:0]   vga_green_data;
  logic [COLOR_BITS-1:0]   vga_blue_data;
  logic                    h_synch;
  logic                    v_synch;
  logic                    blank;
  logic [1:0]              mode;
  logic [3*COLOR_BITS-1:0] fill_rgb;
  logic                    VGA_HSYNCH;
  logic                    VGA_VSYNCH;
  logic [COLOR_BITS-1:0]   VGA_OUT_RED;
  logic [COLOR_BITS-1:0]   VGA_OUT_GREEN;
  logic [COLOR_BITS-1:0]   VGA_OUT_BLUE;
  logic [1:0]              active_mode;

  modport master (
    output vga_red_data, vga_green_data, vga_blue_data,
    output h_synch, v_synch, blank, mode, fill_rgb,
    input  VGA_HSYNCH, VGA_VSYNCH,
    input  VGA_OUT_RED, VGA_OUT_GREEN, VGA_OUT_BLUE, active_mode
  );

  modport slave (
    input  vga_red_data, vga_green_data, vga_blue_data,
    input  h_synch, v_synch, blank, mode, fill_rgb,
    output VGA_HSYNCH, VGA_VSYNCH,
    output VGA_OUT_RED, VGA_OUT_GREEN, VGA_OUT_BLUE, active_mode
  );
endinterface

// File: rtl/vga_video_out_pipe.sv
// VGA output stage: colour selection (pass-through, fill, bars, black) in
// stage 1, then pure delay stages so syncs and colour leave aligned.
module vga_video_out_pipe #(
  parameter int COLOR_BITS       = 4,
  parameter int PIPE_DEPTH       = 2,
  parameter int HSYNC_ACTIVE_LOW = 1,
  parameter int VSYNC_ACTIVE_LOW = 1,
  parameter int BAR_WIDTH        = 80
) (
  input logic                 pixel_clock,
  input logic                 reset,
  vga_video_out_pipe_if.slave vif
);
  localparam int              CW        = 3 * COLOR_BITS;
  localparam int              SW        = CW + 2;
  localparam logic            HS_INV    = (HSYNC_ACTIVE_LOW != 0);
  localparam logic            VS_INV    = (VSYNC_ACTIVE_LOW != 0);
  localparam logic [SW-1:0]   IDLE_WORD = {{CW{1'b0}}, HS_INV, VS_INV};
  localparam logic [11:0]     BAR_DIV   = 12'(BAR_WIDTH);
  localparam logic [11:0]     CNT_MAX   = 12'hFFF;

  logic [1:0]    mode_q;
  logic [CW-1:0] fill_q;
  logic [11:0]   pix_cnt_q;
  logic [11:0]   pix_cnt_d;
  logic          vs_prev_q;
  logic          latch_s;
  logic [11:0]   bar_quot_s;
  logic [2:0]    bar_idx_s;
  logic [2:0]    bar_rgb_s;
  logic [CW-1:0] color_s;
  logic [SW-1:0] stage1_d;
  logic [SW-1:0] pipe_q [PIPE_DEPTH];

  assign latch_s    = vif.v_synch & ~vs_prev_q;
  assign bar_quot_s = pix_cnt_q / BAR_DIV;

  // Stage-1 colour selection and next pixel-counter value.
  always_comb begin
    bar_idx_s = (bar_quot_s > 12'd7) ? 3'd7 : bar_quot_s[2:0];
    case (bar_idx_s)
      3'd0:    bar_rgb_s = 3'b111;
      3'd1:    bar_rgb_s = 3'b110;
      3'd2:    bar_rgb_s = 3'b011;
      3'd3:    bar_rgb_s = 3'b010;
      3'd4:    bar_rgb_s = 3'b101;
      3'd5:    bar_rgb_s = 3'b100;
      3'd6:    bar_rgb_s = 3'b001;
      default: bar_rgb_s = 3'b000;
    endcase

    color_s = {CW{1'b0}};
    if (vif.blank) begin
      color_s = {CW{1'b0}};
    end else begin
      case (mode_q)
        2'd0:    color_s = {vif.vga_red_data, vif.vga_green_data, vif.vga_blue_data};
        2'd1:    color_s = fill_q;
        2'd2:    color_s = {{COLOR_BITS{bar_rgb_s[2]}},
                            {COLOR_BITS{bar_rgb_s[1]}},
                            {COLOR_BITS{bar_rgb_s[0]}}};
        default: color_s = {CW{1'b0}};
      endcase
    end

    stage1_d = {color_s, vif.h_synch ^ HS_INV, vif.v_synch ^ VS_INV};

    if (vif.blank) begin
      pix_cnt_d = 12'd0;
    end else if (pix_cnt_q != CNT_MAX) begin
      pix_cnt_d = pix_cnt_q + 12'd1;
    end else begin
      pix_cnt_d = pix_cnt_q;
    end
  end

  // Frame-boundary mode/fill latch, pixel counter and delay pipeline.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      mode_q    <= 2'd0;
      fill_q    <= {CW{1'b0}};
      pix_cnt_q <= 12'd0;
      vs_prev_q <= 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= IDLE_WORD;
      end
    end else begin
      vs_prev_q <= vif.v_synch;
      pix_cnt_q <= pix_cnt_d;
      if (latch_s) begin
        mode_q <= vif.mode;
        fill_q <= vif.fill_rgb;
      end
      pipe_q[0] <= stage1_d;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign vif.VGA_OUT_RED   = pipe_q[PIPE_DEPTH-1][SW-1 -: COLOR_BITS];
  assign vif.VGA_OUT_GREEN = pipe_q[PIPE_DEPTH-1][SW-1-COLOR_BITS -: COLOR_BITS];
  assign vif.VGA_OUT_BLUE  = pipe_q[PIPE_DEPTH-1][2 +: COLOR_BITS];
  assign vif.VGA_HSYNCH    = pipe_q[PIPE_DEPTH-1][1];
  assign vif.VGA_VSYNCH    = pipe_q[PIPE_DEPTH-1][0];
  assign vif.active_mode   = mode_q;
endmodule

// File: tb/tb_vga_video_out_pipe.sv
// Bench for vga_video_out_pipe: two configurations driven with the same
// stimulus, checked every cycle against a frame-level behavioural model.
module tb_vga_video_out_pipe;
  localparam int D1 = 2, BW1 = 80;
  localparam int D2 = 4, BW2 = 3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
  } px_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  red, grn, blu;
  logic        hs_in, vs_in, blank_in;
  logic [1:0]  mode_in;
  logic [11:0] fill_in;

  int n_checks = 0;
  int n_err    = 0;

  vga_video_out_pipe_if #(.COLOR_BITS(4)) if1 ();
  vga_video_out_pipe_if #(.COLOR_BITS(4)) if2 ();

  assign if1.vga_red_data = red;   assign if2.vga_red_data = red;
  assign if1.vga_green_data = grn; assign if2.vga_green_data = grn;
  assign if1.vga_blue_data = blu;  assign if2.vga_blue_data = blu;
  assign if1.h_synch = hs_in;      assign if2.h_synch = hs_in;
  assign if1.v_synch = vs_in;      assign if2.v_synch = vs_in;
  assign if1.blank = blank_in;     assign if2.blank = blank_in;
  assign if1.mode = mode_in;       assign if2.mode = mode_in;
  assign if1.fill_rgb = fill_in;   assign if2.fill_rgb = fill_in;

  vga_video_out_pipe #(
    .COLOR_BITS(4), .PIPE_DEPTH(D1), .HSYNC_ACTIVE_LOW(1),
    .VSYNC_ACTIVE_LOW(1), .BAR_WIDTH(BW1)
  ) dut1 (.pixel_clock(clk), .reset(rst_n), .vif(if1));

  vga_video_out_pipe #(
    .COLOR_BITS(4), .PIPE_DEPTH(D2), .HSYNC_ACTIVE_LOW(0),
    .VSYNC_ACTIVE_LOW(1), .BAR_WIDTH(BW2)
  ) dut2 (.pixel_clock(clk), .reset(rst_n), .vif(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0]  bar_tbl [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                               3'b101, 3'b100, 3'b001, 3'b000};
  logic [1:0]  m_mode;
  logic [11:0] m_fill;
  int          m_run;
  logic        m_vs_prev;
  px_t         q1[$], q2[$];
  px_t         e1, e2;
  logic [1:0]  eam;
  px_t         idle1, idle2;

  assign idle1 = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b1, vs: 1'b1};
  assign idle2 = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b0, vs: 1'b1};

  function automatic px_t model_px(int bw, bit hs_low);
    px_t        p;
    int         idx;
    logic [2:0] bar;
    p    = '0;
    p.hs = hs_low ? ~hs_in : hs_in;
    p.vs = ~vs_in;
    if (!blank_in) begin
      case (m_mode)
        2'd0: {p.r, p.g, p.b} = {red, grn, blu};
        2'd1: {p.r, p.g, p.b} = m_fill;
        2'd2: begin
          idx = m_run / bw;
          if (idx > 7) idx = 7;
          bar = bar_tbl[idx];
          p.r = bar[2] ? 4'hF : 4'h0;
          p.g = bar[1] ? 4'hF : 4'h0;
          p.b = bar[0] ? 4'hF : 4'h0;
        end
        default: ;
      endcase
    end
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 2'd0; m_fill = 12'h000; m_run = 0; m_vs_prev = 1'b0;
    q1.delete(); q2.delete();
    for (int i = 0; i < D1 - 1; i++) q1.push_back(idle1);
    for (int i = 0; i < D2 - 1; i++) q2.push_back(idle2);
  endtask

  // One compare process: model advances at each edge, outputs checked 1 time unit later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
        e1 = idle1; e2 = idle2; eam = 2'd0;
      end else begin
        q1.push_back(model_px(BW1, 1'b1));
        q2.push_back(model_px(BW2, 1'b0));
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        if (vs_in && !m_vs_prev) begin
          m_mode = mode_in;
          m_fill = fill_in;
        end
        m_vs_prev = vs_in;
        m_run = blank_in ? 0 : ((m_run < 4095) ? m_run + 1 : 4095);
        eam = m_mode;
      end
      #1;
      check("m1_rgb", 32'({if1.VGA_OUT_RED, if1.VGA_OUT_GREEN, if1.VGA_OUT_BLUE}), 32'({e1.r, e1.g, e1.b}));
      check("m1_sync", 32'({if1.VGA_HSYNCH, if1.VGA_VSYNCH}), 32'({e1.hs, e1.vs}));
      check("m1_mode", 32'(if1.active_mode), 32'(eam));
      check("m2_rgb", 32'({if2.VGA_OUT_RED, if2.VGA_OUT_GREEN, if2.VGA_OUT_BLUE}), 32'({e2.r, e2.g, e2.b}));
      check("m2_sync", 32'({if2.VGA_HSYNCH, if2.VGA_VSYNCH}), 32'({e2.hs, e2.vs}));
      check("m2_mode", 32'(if2.active_mode), 32'(eam));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rgb1();
    return 32'({if1.VGA_OUT_RED, if1.VGA_OUT_GREEN, if1.VGA_OUT_BLUE});
  endfunction

  function automatic logic [31:0] rgb2();
    return 32'({if2.VGA_OUT_RED, if2.VGA_OUT_GREEN, if2.VGA_OUT_BLUE});
  endfunction

  int nlines, act_len, vs_at;

  initial begin
    rst_n = 1'b0; red = 4'h0; grn = 4'h0; blu = 4'h0;
    hs_in = 1'b0; vs_in = 1'b0; blank_in = 1'b1; mode_in = 2'd0; fill_in = 12'h000;
    step(); step();
    check("rst_rgb1", rgb1(), 32'h000);
    check("rst_sync1", 32'({if1.VGA_HSYNCH, if1.VGA_VSYNCH}), 32'h3);
    check("rst_sync2", 32'({if2.VGA_HSYNCH, if2.VGA_VSYNCH}), 32'h1);
    check("rst_mode", 32'(if1.active_mode), 32'h0);

    // pass-through, active-low hsync
    rst_n = 1'b1; blank_in = 1'b0; red = 4'hA; grn = 4'h5; blu = 4'h3; hs_in = 1'b1;
    step(); step();
    check("pass_rgb", rgb1(), 32'hA53);
    check("pass_hs", 32'(if1.VGA_HSYNCH), 32'h0);

    // blank forces black, syncs still follow
    blank_in = 1'b1; red = 4'hF; hs_in = 1'b0;
    step(); step();
    check("blank_rgb", rgb1(), 32'h000);
    check("blank_hs", 32'(if1.VGA_HSYNCH), 32'h1);

    // single-cycle hsync pulse through the 4-deep active-high instance
    blank_in = 1'b0; red = 4'h0; grn = 4'h0; blu = 4'h0;
    repeat (4) step();
    hs_in = 1'b1; red = 4'h7; grn = 4'hE; blu = 4'h1;
    step();
    hs_in = 1'b0; red = 4'h0; grn = 4'h0; blu = 4'h0;
    step(); step();
    check("d4_hs_pre", 32'(if2.VGA_HSYNCH), 32'h0);
    check("d4_rgb_pre", rgb2(), 32'h000);
    step();
    check("d4_hs_on", 32'(if2.VGA_HSYNCH), 32'h1);
    check("d4_rgb_on", rgb2(), 32'h7E1);
    step();
    check("d4_hs_post", 32'(if2.VGA_HSYNCH), 32'h0);
    check("d4_rgb_post", rgb2(), 32'h000);

    // mid-frame mode change is ignored until the next v_synch rise
    red = 4'hA; grn = 4'h5; blu = 4'h3; mode_in = 2'd1; fill_in = 12'h0F0;
    repeat (3) step();
    check("mid_mode", 32'(if1.active_mode), 32'h0);
    check("mid_rgb", rgb1(), 32'hA53);
    vs_in = 1'b1;
    step();
    check("latch_mode", 32'(if1.active_mode), 32'h1);
    step();
    check("latch_edge_rgb", rgb1(), 32'hA53);
    step();
    check("fill_rgb", rgb1(), 32'h0F0);
    mode_in = 2'd0;
    repeat (3) step();
    check("hold_mode", 32'(if1.active_mode), 32'h1);
    check("hold_rgb", rgb1(), 32'h0F0);

    // colour bars over a 640-pixel line
    vs_in = 1'b0; blank_in = 1'b1;
    step();
    mode_in = 2'd2; vs_in = 1'b1;
    step();
    vs_in = 1'b0;
    step();
    check("bar_mode", 32'(if1.active_mode), 32'h2);
    for (int i = 0; i < 642; i++) begin
      blank_in = (i < 640) ? 1'b0 : 1'b1;
      step();
      if (i == 1)   check("bar_px0", rgb1(), 32'hFFF);
      if (i == 80)  check("bar_px79", rgb1(), 32'hFFF);
      if (i == 81)  check("bar_px80", rgb1(), 32'hFF0);
      if (i == 561) check("bar_px560", rgb1(), 32'h000);
    end
    blank_in = 1'b0;
    step(); step();
    check("bar_clear", rgb1(), 32'hFFF);

    // asynchronous reset mid-line
    rst_n = 1'b0;
    #1;
    check("arst_rgb", rgb1(), 32'h000);
    check("arst_sync", 32'({if1.VGA_HSYNCH, if1.VGA_VSYNCH}), 32'h3);
    check("arst_mode", 32'(if1.active_mode), 32'h0);
    step();
    rst_n = 1'b1; red = 4'hC; grn = 4'h3; blu = 4'h9; hs_in = 1'b1;
    step(); step();
    check("post_rst_rgb", rgb1(), 32'hC39);
    check("post_rst_hs", 32'(if1.VGA_HSYNCH), 32'h0);
    hs_in = 1'b0;

    // randomized frames checked by the model
    for (int f = 0; f < 4; f++) begin
      nlines = $urandom_range(6, 10);
      for (int l = 0; l < nlines; l++) begin
        act_len = ($urandom_range(0, 3) == 0) ? $urandom_range(600, 700) : $urandom_range(1, 40);
        vs_at   = $urandom_range(0, act_len - 1);
        for (int p = 0; p < act_len; p++) begin
          blank_in = 1'b0; hs_in = 1'b0;
          red = 4'($urandom); grn = 4'($urandom); blu = 4'($urandom);
          if (l == 0 && p == vs_at) vs_in = 1'b1;
          if (l == 2 && p == 0) vs_in = 1'b0;
          if ($urandom_range(0, 7) == 0) begin
            mode_in = 2'($urandom_range(0, 3));
            fill_in = 12'($urandom);
          end
          rst_n = (f == 2 && l == 3 && p == 0) ? 1'b0 : 1'b1;
          step();
        end
        rst_n = 1'b1;
        for (int h = 0; h < 4; h++) begin
          blank_in = 1'b1; hs_in = (h == 1 || h == 2) ? 1'b1 : 1'b0;
          red = 4'($urandom); grn = 4'($urandom); blu = 4'($urandom);
          step();
        end
      end
    end

    repeat (D2 + 1) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
